// File: rtl/mem_line_ctrl_pkg.sv
// Shared constants for mem_line_ctrl: FSM encoding, default access latency and line width.
// MEM_DATA_WIDTH normally comes from header.vh; the fallback below only applies when it is absent.
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 128
`endif

package mem_line_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int DEFAULT_LATENCY = 5;
    localparam int CNT_W           = 4;
    localparam int MEM_LINE_W      = `MEM_DATA_WIDTH;

    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable 4-bit down-counter; done_o flags terminal count (zero) and the count holds there.
module mem_lat_counter
    import mem_line_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_line_ctrl.sv
// Miss-service sequencer between the data cache and main_memory: optional victim writeback, then optional fill.
// Optional feature: MEM_LINE_CTRL_PERF_EN adds rd_count/wr_count access counters.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WB    | writing victim line, mem_wrt_en held for LATENCY cycles
// FILL  | reading missing line for LATENCY cycles, captured on the last one
// RESP  | one-cycle resp_valid pulse
module mem_line_ctrl
    import mem_line_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = `MEM_DATA_WIDTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [LINE_W-1:0] req_wb_data,
    input  logic              req_fill,
    input  logic [ADDR_W-1:0] req_fill_addr,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_data_to_write,
    output logic              mem_wrt_en,
    input  logic [LINE_W-1:0] mem_data_to_read
`ifdef MEM_LINE_CTRL_PERF_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

    state_e            state_q;
    logic              req_fill_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic              resp_valid_q;
    logic [LINE_W-1:0] resp_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic              mem_wrt_en_q;

    logic cnt_load_d;
    logic cnt_dec_d;
    logic cnt_done;

    // Reload on every entry into an access state: from IDLE, or WB handing over to FILL.
    always_comb begin
        cnt_load_d = 1'b0;
        cnt_dec_d  = 1'b0;
        case (state_q)
            IDLE: cnt_load_d = req_valid && (req_wb || req_fill);
            WB: begin
                cnt_load_d = cnt_done && req_fill_q;
                cnt_dec_d  = 1'b1;
            end
            FILL: cnt_dec_d = 1'b1;
            default: ;
        endcase
    end

    mem_lat_counter u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_d),
        .load_val_i (lat_load(LATENCY)),
        .dec_i      (cnt_dec_d),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_fill_q   <= 1'b0;
            fill_addr_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wrt_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        req_fill_q  <= req_fill;
                        fill_addr_q <= req_fill_addr;
                        if (req_wb) begin
                            state_q      <= WB;
                            mem_addr_q   <= req_wb_addr & ADDR_MASK;
                            mem_wdata_q  <= req_wb_data;
                            mem_wrt_en_q <= 1'b1;
                        end else if (req_fill) begin
                            state_q    <= FILL;
                            mem_addr_q <= req_fill_addr & ADDR_MASK;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (cnt_done) begin
                        mem_wrt_en_q <= 1'b0;
                        mem_wdata_q  <= '0;
                        if (req_fill_q) begin
                            state_q    <= FILL;
                            mem_addr_q <= fill_addr_q & ADDR_MASK;
                        end else begin
                            state_q      <= RESP;
                            mem_addr_q   <= '0;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (cnt_done) begin
                        resp_data_q  <= mem_data_to_read;
                        state_q      <= RESP;
                        mem_addr_q   <= '0;
                        resp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready         = (state_q == IDLE);
    assign busy              = (state_q != IDLE);
    assign resp_valid        = resp_valid_q;
    assign resp_data         = resp_data_q;
    assign mem_addr          = mem_addr_q;
    assign mem_data_to_write = mem_wdata_q;
    assign mem_wrt_en        = mem_wrt_en_q;

`ifdef MEM_LINE_CTRL_PERF_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if ((state_q == FILL) && cnt_done) rd_count_q <= rd_count_q + 32'd1;
            if ((state_q == WB) && cnt_done)   wr_count_q <= wr_count_q + 32'd1;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Self-checking bench for mem_line_ctrl with a behavioural main memory and a transaction-level reference.
module tb_mem_line_ctrl;

    localparam int LW  = mem_line_ctrl_pkg::MEM_LINE_W;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_wb, req_fill;
    logic [31:0]   req_wb_addr, req_fill_addr;
    logic [LW-1:0] req_wb_data;
    logic          req_ready, resp_valid, busy, mem_wrt_en;
    logic [LW-1:0] resp_data, mem_data_to_write, mem_data_to_read;
    logic [31:0]   mem_addr;
`ifdef MEM_LINE_CTRL_PERF_EN
    logic [31:0]   rd_count, wr_count;
`endif

    int errors = 0;
    int checks = 0;
    int exp_rd = 0;
    int exp_wr = 0;
    logic [LW-1:0] last_fill = '0;
    logic [LW-1:0] mem     [0:4095];
    logic [LW-1:0] ref_mem [0:4095];
    logic [LW-1:0] mem_rd;

    always #5 clk = ~clk;

    mem_line_ctrl #(.ADDR_W(32), .LINE_W(LW), .LATENCY(LAT)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_wb            (req_wb),
        .req_wb_addr       (req_wb_addr),
        .req_wb_data       (req_wb_data),
        .req_fill          (req_fill),
        .req_fill_addr     (req_fill_addr),
        .resp_valid        (resp_valid),
        .resp_data         (resp_data),
        .busy              (busy),
        .mem_addr          (mem_addr),
        .mem_data_to_write (mem_data_to_write),
        .mem_wrt_en        (mem_wrt_en),
        .mem_data_to_read  (mem_data_to_read)
`ifdef MEM_LINE_CTRL_PERF_EN
        ,
        .rd_count          (rd_count),
        .wr_count          (wr_count)
`endif
    );

    // Main memory: one line per word-address key, writes on the clock edge, reads settle mid-cycle.
    always @(posedge clk) if (mem_wrt_en === 1'b1) mem[mem_addr[13:2]] = mem_data_to_write;
    always @(negedge clk) mem_rd <= mem[mem_addr[13:2]];
    assign mem_data_to_read = mem_rd;

    function automatic logic [LW-1:0] default_line(input logic [31:0] k);
        return LW'({k, ~k, k ^ 32'h1234_5678, k + 32'd1});
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r = '0;
        for (int i = 0; i < LW; i += 32) r = (r << 32) | LW'($urandom);
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic scramble_inputs();
        req_wb        = 1'($urandom);
        req_fill      = 1'($urandom);
        req_wb_addr   = $urandom;
        req_fill_addr = $urandom;
        req_wb_data   = rand_line();
    endtask

    // Watches one request cycle by cycle, starting just after its accept edge (edge 0).
    task automatic monitor_req(input logic wb, input logic [31:0] wa, input logic [LW-1:0] wd,
                               input logic fill, input logic [31:0] fa, input string tag);
        int wb_c = wb ? LAT : 0;
        int fl_c = fill ? LAT : 0;
        int rc   = wb_c + fl_c + 1;
        logic [LW-1:0] prev = last_fill;
        logic [LW-1:0] e_data;
        logic [31:0]   e_addr;
        logic          e_wen, e_rv, e_idle, chk_wdata;
        logic [LW-1:0] e_wdata;
        if (wb) ref_mem[wa[13:2]] = wd;
        if (fill) last_fill = ref_mem[fa[13:2]];
        for (int k = 1; k <= rc + 1; k++) begin
            @(negedge clk);
            e_wen = 1'b0; e_rv = 1'b0; e_idle = 1'b0; e_addr = '0; e_wdata = '0; chk_wdata = 1'b1;
            if (k <= wb_c) begin
                e_wen = 1'b1; e_addr = wa & ~32'd3; e_wdata = wd;
            end else if (k <= wb_c + fl_c) begin
                e_addr = fa & ~32'd3; chk_wdata = 1'b0;
            end else if (k == rc) begin
                e_rv = 1'b1;
            end else begin
                e_idle = 1'b1;
            end
            e_data = (k < rc) ? prev : last_fill;
            checks++;
            if (mem_wrt_en !== e_wen) begin
                errors++; $display("FAIL %s wrt_en cycle %0d: got %b want %b", tag, k, mem_wrt_en, e_wen);
            end
            checks++;
            if (mem_addr !== e_addr) begin
                errors++; $display("FAIL %s mem_addr cycle %0d: got %h want %h", tag, k, mem_addr, e_addr);
            end
            checks++;
            if (resp_valid !== e_rv) begin
                errors++; $display("FAIL %s resp_valid cycle %0d: got %b want %b", tag, k, resp_valid, e_rv);
            end
            checks++;
            if (req_ready !== e_idle || busy !== !e_idle) begin
                errors++; $display("FAIL %s ready/busy cycle %0d: got %b/%b want %b/%b", tag, k, req_ready, busy, e_idle, !e_idle);
            end
            checks++;
            if (resp_data !== e_data) begin
                errors++; $display("FAIL %s resp_data cycle %0d: got %h want %h", tag, k, resp_data, e_data);
            end
            if (chk_wdata) begin
                checks++;
                if (mem_data_to_write !== e_wdata) begin
                    errors++; $display("FAIL %s wdata cycle %0d: got %h want %h", tag, k, mem_data_to_write, e_wdata);
                end
            end
        end
        exp_rd += int'(fill);
        exp_wr += int'(wb);
`ifdef MEM_LINE_CTRL_PERF_EN
        checks++;
        if (rd_count !== 32'(exp_rd) || wr_count !== 32'(exp_wr)) begin
            errors++; $display("FAIL %s perf counts: got rd=%0d wr=%0d want rd=%0d wr=%0d", tag, rd_count, wr_count, exp_rd, exp_wr);
        end
`endif
    endtask

    task automatic issue(input logic wb, input logic [31:0] wa, input logic [LW-1:0] wd,
                         input logic fill, input logic [31:0] fa, input string tag);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready before issue: got %b want 1", tag, req_ready);
        end
        req_wb = wb; req_wb_addr = wa; req_wb_data = wd; req_fill = fill; req_fill_addr = fa;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_inputs();
        monitor_req(wb, wa, wd, fill, fa, tag);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== '0 || busy !== 1'b0 || mem_addr !== '0 ||
            mem_data_to_write !== '0 || mem_wrt_en !== 1'b0) begin
            errors++; $display("FAIL reset outputs: got rv=%b rd=%h busy=%b addr=%h wd=%h wen=%b want all 0",
                               resp_valid, resp_data, busy, mem_addr, mem_data_to_write, mem_wrt_en);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset release: got ready=%b busy=%b want 1/0", req_ready, busy);
        end
    endtask

    task automatic test_fill_only();
        logic [LW-1:0] line = LW'(128'h0000_0803_0000_0802_0000_0801_0000_0800);
        mem[12'h800] = line;
        ref_mem[12'h800] = line;
        issue(1'b0, $urandom, rand_line(), 1'b1, 32'h0000_2003, "fill_only");
    endtask

    task automatic test_wb_then_fill();
        logic [LW-1:0] pat = LW'(128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555);
        issue(1'b1, 32'h40, pat, 1'b1, 32'h40, "wb_fill_same");
    endtask

    task automatic test_empty();
        issue(1'b0, $urandom, rand_line(), 1'b0, $urandom, "empty");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_wa = rand_addr(), a_fa = rand_addr(), b_wa = rand_addr(), b_fa = rand_addr();
        logic [LW-1:0] a_wd = rand_line(), b_wd = rand_line();
        req_wb = 1'b1; req_wb_addr = a_wa; req_wb_data = a_wd; req_fill = 1'b1; req_fill_addr = a_fa;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_wb = 1'b1; req_wb_addr = b_wa; req_wb_data = b_wd; req_fill = 1'b0; req_fill_addr = b_fa;
        monitor_req(1'b1, a_wa, a_wd, 1'b1, a_fa, "b2b_first");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_inputs();
        monitor_req(1'b1, b_wa, b_wd, 1'b0, b_fa, "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            issue(1'($urandom), rand_addr(), rand_line(), 1'($urandom), rand_addr(), "random");
        end
    endtask

    task automatic test_reset_mid_wb();
        logic [LW-1:0] wd = rand_line();
        req_wb = 1'b1; req_wb_addr = 32'h3F00; req_wb_data = wd; req_fill = 1'b1; req_fill_addr = rand_addr();
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (mem_wrt_en !== 1'b1) begin
            errors++; $display("FAIL abort wb cycle 3 wrt_en: got %b want 1", mem_wrt_en);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_wrt_en !== 1'b0 || mem_addr !== '0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL abort async: got wen=%b addr=%h busy=%b rv=%b want 0", mem_wrt_en, mem_addr, busy, resp_valid);
        end
        ref_mem[12'hFC0] = wd;
        last_fill = '0;
        exp_rd = 0;
        exp_wr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 2 * LAT + 2; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || mem_wrt_en !== 1'b0 ||
                mem_addr !== '0 || mem_data_to_write !== '0 || resp_data !== '0) begin
                errors++; $display("FAIL abort idle %0d: got rv=%b ready=%b busy=%b wen=%b addr=%h rd=%h", k,
                                   resp_valid, req_ready, busy, mem_wrt_en, mem_addr, resp_data);
            end
        end
    endtask

    task automatic test_perf();
        issue(1'b1, rand_addr(), rand_line(), 1'b1, rand_addr(), "perf_1");
        issue(1'b0, rand_addr(), rand_line(), 1'b1, rand_addr(), "perf_2");
        issue(1'b1, rand_addr(), rand_line(), 1'b1, rand_addr(), "perf_3");
`ifdef MEM_LINE_CTRL_PERF_EN
        checks++;
        if (rd_count !== 32'd3 || wr_count !== 32'd2) begin
            errors++; $display("FAIL perf totals: got rd=%0d wr=%0d want rd=3 wr=2", rd_count, wr_count);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = default_line(32'(i));
            ref_mem[i] = default_line(32'(i));
        end
        test_reset();
        test_fill_only();
        test_wb_then_fill();
        test_empty();
        test_back_to_back();
        test_random();
        test_reset_mid_wb();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
